pipe_stage_hs: RTL
==================

# pipe_stage_hs

Parametrised pipeline stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB) in the pipelined CPU. It replaces the fixed-width, per-field stage registers driven by a bare write enable with a single WIDTH-bit payload stage. The stage uses a valid/ready handshake, a synchronous flush for branch/exception squash, and an optional two-entry skid mode that sustains one beat per cycle while keeping `in_ready` registered.

## Interface
- `WIDTH`, 32: payload width in bits; concatenation of all stage fields.
- `SKID`, 1: 1 = two-entry skid mode with registered `in_ready`; 0 = single register with combinational ready pass-through.
- `RESET_VAL`, {WIDTH{1'b0}}: value loaded into payload registers on reset.
- `clock`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low reset. Asserting it (0) at a rising edge clears the stage.
- `flush`  in  1  synchronous squash; invalidates all held beats.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  stage can accept a beat this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` holds a valid beat.
- `out_ready`  in  1  downstream consumes the beat this cycle.
- `out_data`  out  WIDTH  payload to the next stage.
- `occupancy`  out  2  number of held beats (0..2; max 1 when SKID=0).

## Operation
- Accept: `in_valid && in_ready` at an edge. Release: `out_valid && out_ready` at an edge.
- SKID=1 state machine (state register also drives `occupancy`):
  - EMPTY: accept → ONE, main ← in_data.
  - ONE: accept and release → ONE, main ← in_data. Accept only → FULL, skid ← in_data. Release only → EMPTY. Neither → hold.
  - FULL: release → ONE, main ← skid. Otherwise hold.
  - `in_ready` = registered (state != FULL). `out_valid` = (state != EMPTY). `out_data` = main.
- SKID=0:
  - `in_ready` = !out_valid || out_ready (combinational).
  - Accept loads main and sets valid. Release without accept clears valid.
- Flush:
  - Forces state EMPTY, `out_valid`=0, `occupancy`=0, `in_ready`=1 next cycle.
  - Flush has priority over accept and release in the same cycle. A beat handshaken in the flush cycle is dropped but counts as consumed upstream.
  - Payload registers are not cleared by flush. `out_data` is don't-care while `out_valid`=0.
- Reset (reset=0): state EMPTY, main and skid ← RESET_VAL.
  - Outputs after the reset edge: `out_valid`=0, `out_data`=RESET_VAL, `occupancy`=0, `in_ready`=1.
  - Reset overrides flush and any handshake. Mid-stream reset discards both held beats.
- `out_data` must not change while `out_valid=1 && out_ready=0` (stable hold rule). Order of beats is strictly preserved.

## Timing
- Latency: 1 cycle from accept to `out_valid` when empty; skid beats add one cycle per queued beat.
- Throughput: 1 beat/cycle in both modes with `out_ready` held high.
- SKID=1: `in_ready` falls the cycle after the second beat is accepted while the output is stalled. It rises the cycle after the first release from FULL.
- SKID=1: no combinational path from `out_ready` to `in_ready`. SKID=0 has one (documented critical path).
- Flush and reset take effect at the edge where they are sampled. Outputs reflect the cleared state in the following cycle.

## Structure
- Shared package `pipe_pkg`: state encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2. Both modes use these for `occupancy`.
- Sub-module `pipe_slot`: WIDTH-parametrised register with load enable and synchronous active-low reset to RESET_VAL. Instantiated twice (main, skid); skid is omitted by generate when SKID=0.
- Stage wrappers (e.g. MEM/WB) pack their fields into `in_data` and unpack `out_data`. No per-field register modules.

## Test plan
- Reset: hold reset=0 for 2 cycles with in_valid=1 and in_data=32'hDEAD_BEEF → out_valid=0, out_data=0, occupancy=0, in_ready=1. The first beat after release appears 1 cycle after accept.
- Streaming: out_ready=1, send 0x1..0x10 back-to-back → outputs 0x1..0x10 in order, one per cycle. in_ready never drops (both SKID values).
- Stall: SKID=1, out_ready=0, send 0xA, 0xB → occupancy=2, in_ready=0, out_data=0xA held. Raise out_ready → 0xA, then 0xB, with in_ready=1 one cycle after the first release.
- Flush: FULL with 0xA/0xB, flush=1 and in_valid=1 with 0xC in the same cycle → next cycle out_valid=0, occupancy=0. 0xC is never output.
- Simultaneous: SKID=1 in ONE holding 0x5, accept 0x6 and release 0x5 in the same cycle → state ONE, out_data=0x6, occupancy=1.
- SKID=0 pass-through: out_valid=1, out_ready=1, in_valid=1 → in_ready=1 in the same cycle, and the replacement beat is output the next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the pipeline stage register.
// The state encoding doubles as the held-beat count, so the stage can drive
// its occupancy output straight from the state register in either mode.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    localparam int unsigned PIPE_MAX_OCC = 2;

endpackage : pipe_pkg

// File: rtl/pipe_slot.sv
// pipe_slot
// WIDTH-bit payload register with load enable and synchronous active-low
// reset to RESET_VAL.
//
// Ports:
//   clock   in   rising-edge clock
//   reset   in   synchronous active-low reset
//   load_i  in   capture data_i at the next edge
//   data_i  in   WIDTH  payload to capture
//   data_o  out  WIDTH  held payload
module pipe_slot #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    assign data_d = load_i ? data_i : data_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule : pipe_slot

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs
// Pipeline stage register with valid/ready handshake and synchronous flush.
// SKID=1: two-entry skid buffer, in_ready decoded from the state register only.
// SKID=0: single register, in_ready passes out_ready through combinationally
//         (this out_ready -> in_ready path is the known critical path).
//
// State | meaning
// ------+--------------------------------------------------------------
// EMPTY | no beat held
// ONE   | one beat held in main, presented on out_data
// FULL  | main presented, second beat waiting in skid (SKID=1 only)
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-low reset
//   flush      in   squash all held beats
//   in_valid   in   upstream beat present
//   in_ready   out  stage accepts a beat this cycle
//   in_data    in   WIDTH  upstream payload
//   out_valid  out  out_data holds a valid beat
//   out_ready  in   downstream consumes the beat this cycle
//   out_data   out  WIDTH  payload to the next stage
//   occupancy  out  2  number of held beats
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int unsigned       WIDTH     = 32,
    parameter bit                SKID      = 1'b1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    pipe_state_e      state_q;
    pipe_state_e      state_d;
    logic             accept;
    logic             rel;
    logic             main_load;
    logic             main_from_skid;
    logic             skid_load;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_data;

    assign accept = in_valid && in_ready;
    assign rel    = out_valid && out_ready;

    always_comb begin
        if (SKID) begin
            in_ready = (state_q != ST_FULL);
        end else begin
            in_ready = (state_q == ST_EMPTY) || out_ready;
        end
    end

    // With SKID=0 the ONE state never sees accept-without-release, because
    // in_ready is low whenever the beat is stalled; FULL is unreachable.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d   = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && rel) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        state_d   = ST_FULL;
                        skid_load = 1'b1;
                    end else if (rel) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (rel) begin
                        state_d        = ST_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign main_d = main_from_skid ? skid_data : in_data;

    pipe_slot #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clock  (clock),
        .reset  (reset),
        .load_i (main_load),
        .data_i (main_d),
        .data_o (out_data)
    );

    generate
        if (SKID) begin : g_skid
            pipe_slot #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_skid (
                .clock  (clock),
                .reset  (reset),
                .load_i (skid_load),
                .data_i (in_data),
                .data_o (skid_data)
            );
        end else begin : g_no_skid
            logic unused_skid_load;
            assign unused_skid_load = skid_load;
            assign skid_data        = RESET_VAL;
        end
    endgenerate

    assign out_valid = (state_q != ST_EMPTY);
    assign occupancy = state_q;

endmodule : pipe_stage_hs
